// File: rtl/draw_scheduler_pkg.sv
// Shared widths, layer identifiers and FSM encoding for the draw scheduler.
package draw_scheduler_pkg;
  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int VGA_C_W = 3;

  localparam int LAYER_BG     = 0;
  localparam int LAYER_SHIP   = 1;
  localparam int LAYER_ENEMY  = 2;
  localparam int LAYER_BULLET = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAYER  = 2'b01,
    ST_UPDATE = 2'b10
  } state_e;
endpackage

// File: rtl/draw_timeout_counter.sv
// Per-layer watchdog: counts cycles while enabled, saturates at TIMEOUT-1
// and flags the terminal count so a stuck layer can be skipped.
module draw_timeout_counter #(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term_s;

  assign at_term_s = (cnt_q == TERM);
  assign tc_o      = enable_i & at_term_s;

  // Clear wins over counting; holding at TERM keeps the counter from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_term_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer that hands the VGA write port to each draw layer in turn,
// then pulses update_en so game state can advance.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic [NUM_LAYERS-1:0]           px_valid,
  input  logic [NUM_LAYERS-1:0]           px_last,
  input  logic [VGA_X_W*NUM_LAYERS-1:0]   px_x,
  input  logic [VGA_Y_W*NUM_LAYERS-1:0]   px_y,
  input  logic [VGA_C_W*NUM_LAYERS-1:0]   px_colour,
  output logic [NUM_LAYERS-1:0]           grant,
  output logic [VGA_X_W-1:0]              vga_x,
  output logic [VGA_Y_W-1:0]              vga_y,
  output logic [VGA_C_W-1:0]              vga_colour,
  output logic                            writeEn,
  output logic                            update_en,
  output logic                            busy,
  output logic                            frame_overrun,
  output logic [NUM_LAYERS-1:0]           layer_timeout
);
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [NUM_LAYERS-1:0] GRANT_ONE = NUM_LAYERS'(1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(LAYER_BG);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LAYERS - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_LAYERS-1:0]   grant_q;
  logic [VGA_X_W-1:0]      vga_x_q;
  logic [VGA_Y_W-1:0]      vga_y_q;
  logic [VGA_C_W-1:0]      vga_colour_q;
  logic                    write_en_q;
  logic                    update_en_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic [NUM_LAYERS-1:0]   timeout_q;

  logic                    in_layer_s;
  logic                    cur_valid_s;
  logic                    cur_done_s;
  logic                    tc_s;
  logic                    advance_s;
  logic [IDX_W-1:0]        next_idx_s;
  logic [VGA_X_W-1:0]      sel_x_s;
  logic [VGA_Y_W-1:0]      sel_y_s;
  logic [VGA_C_W-1:0]      sel_c_s;

  assign in_layer_s  = (state_q == ST_LAYER);
  assign cur_valid_s = in_layer_s & px_valid[idx_q];
  assign cur_done_s  = cur_valid_s & px_last[idx_q];
  assign advance_s   = in_layer_s & (cur_done_s | tc_s);
  assign next_idx_s  = idx_q + IDX_W'(1);

  // Only the granted layer's pixel is ever routed towards the VGA registers.
  assign sel_x_s = px_x[int'(idx_q)*VGA_X_W +: VGA_X_W];
  assign sel_y_s = px_y[int'(idx_q)*VGA_Y_W +: VGA_Y_W];
  assign sel_c_s = px_colour[int'(idx_q)*VGA_C_W +: VGA_C_W];

  draw_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!in_layer_s || advance_s),
    .enable_i (in_layer_s),
    .tc_o     (tc_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_FIRST;
      grant_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      write_en_q   <= 1'b0;
      update_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= '0;
    end else begin
      write_en_q  <= 1'b0;
      update_en_q <= 1'b0;
      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            state_q <= ST_LAYER;
            idx_q   <= IDX_FIRST;
            grant_q <= GRANT_ONE;
            busy_q  <= 1'b1;
          end
        end
        ST_LAYER: begin
          if (cur_valid_s) begin
            vga_x_q      <= sel_x_s;
            vga_y_q      <= sel_y_s;
            vga_colour_q <= sel_c_s;
            write_en_q   <= 1'b1;
          end
          if (tc_s && !cur_done_s) begin
            timeout_q[idx_q] <= 1'b1;
          end
          if (advance_s) begin
            if (idx_q == IDX_LAST) begin
              state_q     <= ST_UPDATE;
              idx_q       <= IDX_FIRST;
              grant_q     <= '0;
              update_en_q <= 1'b1;
            end else begin
              idx_q   <= next_idx_s;
              grant_q <= GRANT_ONE << next_idx_s;
            end
          end
        end
        ST_UPDATE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= IDX_FIRST;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = vga_colour_q;
  assign writeEn       = write_en_q;
  assign update_en     = update_en_q;
  assign busy          = busy_q;
  assign frame_overrun = overrun_q;
  assign layer_timeout = timeout_q;
endmodule
